approx_add_arbiter: RTL

APPROX_ADD_ARBITER -- requirements
Module: approx_add_arbiter

---
 rtl/approx_add_arbiter_pkg.sv | 13 +
 rtl/approx_add_arbiter_adder.sv | 28 ++
 rtl/approx_add_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/approx_add_arbiter_pkg.sv
// Shared definitions for the approximate-adder arbiter: default geometry and FSM state encoding.
package approx_add_arbiter_pkg;

    localparam int DEF_DW      = 20;
    localparam int DEF_PORTION = 4;
    localparam int DEF_NREQ    = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/approx_add_arbiter_adder.sv
// Approximate adder: OR-combined low field, exact upper add seeded by the top bit pair of the low field.
module approx_adder_4th
    import approx_add_arbiter_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int PORTION = DEF_PORTION
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    localparam int L = DW / PORTION;

    logic            carry_in_s;
    logic [DW-L-1:0] hi_sum_s;
    logic [L-1:0]    lo_sum_s;

    // Upper field wraps naturally at its own width, which drops the carry-out.
    always_comb begin
        carry_in_s = a[L-1] & b[L-1];
        lo_sum_s   = a[L-1:0] | b[L-1:0];
        hi_sum_s   = a[DW-1:L] + b[DW-1:L] + {{(DW-L-1){1'b0}}, carry_in_s};
    end

    assign sum = {hi_sum_s, lo_sum_s};

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter time-sharing one approximate adder; a single result slot with full throughput.
module approx_add_arbiter
    import approx_add_arbiter_pkg::*;
#(
    parameter  int DW      = DEF_DW,
    parameter  int PORTION = DEF_PORTION,
    parameter  int NREQ    = DEF_NREQ,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_sum,
    output logic [15:0]        op_cnt
);

    state_e          state_r;
    logic            rsp_valid_r;
    logic [DW-1:0]   rsp_sum_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [15:0]     op_cnt_r;

    logic            hi_found_s;
    logic            lo_found_s;
    logic [IDW-1:0]  hi_idx_s;
    logic [IDW-1:0]  lo_idx_s;
    logic            found_s;
    logic [IDW-1:0]  grant_s;
    logic [IDW-1:0]  next_ptr_s;
    logic            slot_free_s;
    logic            take_s;
    logic [DW-1:0]   op_a_s;
    logic [DW-1:0]   op_b_s;
    logic [DW-1:0]   sum_s;

    // Round-robin pick: lowest valid index at/after rr_ptr, else lowest valid index overall (wrap).
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = IDW'(i);
                if (IDW'(i) >= rr_ptr_r) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = IDW'(i);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        found_s = lo_found_s;
        grant_s = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // The slot can accept when empty or when its current result leaves this cycle; never during reset.
    always_comb begin
        slot_free_s = rst_n & ((state_r == ST_EMPTY) | ((state_r == ST_FULL) & rsp_ready));
        take_s      = slot_free_s & found_s;
        next_ptr_s  = (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + IDW'(1);
    end

    // One-hot accept for the granted requester.
    always_comb begin
        req_ready = '0;
        if (take_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Grant-indexed operand mux feeding the shared adder.
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s == IDW'(i)) begin
                op_a_s = req_a[i*DW +: DW];
                op_b_s = req_b[i*DW +: DW];
            end else begin
                op_a_s = op_a_s;
                op_b_s = op_b_s;
            end
        end
    end

    approx_adder_4th #(
        .DW      (DW),
        .PORTION (PORTION)
    ) u_adder (
        .a   (op_a_s),
        .b   (op_b_s),
        .sum (sum_s)
    );

    // Result-slot FSM; a new grant while FULL overwrites the departing result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            rsp_valid_r <= 1'b0;
            rsp_sum_r   <= '0;
            rsp_id_r    <= '0;
            rr_ptr_r    <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (take_s) begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                        rsp_sum_r   <= sum_s;
                        rsp_id_r    <= grant_s;
                        rr_ptr_r    <= next_ptr_s;
                    end else begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (take_s) begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                        rsp_sum_r   <= sum_s;
                        rsp_id_r    <= grant_s;
                        rr_ptr_r    <= next_ptr_s;
                    end else if (rsp_ready) begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Completed-transfer counter, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_r <= 16'd0;
        end else if (rsp_valid_r & rsp_ready) begin
            op_cnt_r <= op_cnt_r + 16'd1;
        end else begin
            op_cnt_r <= op_cnt_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_id    = rsp_id_r;
    assign op_cnt    = op_cnt_r;

endmodule
